alu_result_capture: RTL and testbench
=====================================

// Module: alu_result_capture
// PURPOSE
//  Downstream stage of the 4-function ALU decoder (add/sub/compare/and). Receives y0..y3, cout
//  and sign together with the 2-bit select, and keeps only the result for the selected op.
//  Derives carry/sign/zero flags and queues result+flags in a DEPTH-entry FIFO. The FIFO output
//  uses a valid/ready handshake. Also counts completed operations for debug/perf readout.
// PARAMETERS
//  W      4  operand/result width (matches ALU y0..y3 width)
//  DEPTH  2  FIFO entries; power of two, >=2
//  CNT_W  8  width of op_count
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  in_valid    in   1      ALU outputs + s are valid this cycle
//  in_ready    out  1      stage can accept (FIFO not full)
//  s           in   2      op select that produced y0..y3: 00 add, 01 sub, 10 cmp, 11 and
//  y0..y3      in   W each ALU results: adder, subtractor, comparator, AND
//  cout        in   1      adder carry-out
//  sign        in   1      subtractor sign (1 = negative)
//  out_valid   out  1      head entry valid
//  out_ready   in   1      consumer takes head this cycle
//  out_op      out  2      select of head entry
//  out_result  out  W      result of head entry
//  out_flags   out  3      {carry, sign, zero} of head entry
//  op_count    out  CNT_W  number of accepted ops, modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO empty, pointers=0, out_valid=0, out_op/result/flags=0,
//    op_count=0, in_ready=1 once the FIFO is empty (combinational from occupancy).
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready. Both are sampled at the clk edge.
//  - Result mux: s=00->y0, 01->y1, 10->y2, 11->y3.
//  - carry = cout only when s=00, else 0. sign flag = sign only when s=01, else 0.
//  - zero = (selected result == 0), for every op.
//  - Entry {s, result, flags} is written at the accept edge. No same-cycle bypass.
//  - Latency: accept at edge N -> out_valid=1 after edge N if the FIFO was empty.
//  - in_ready = (count != DEPTH). When full, in_ready=0 even if a pop occurs the same cycle.
//    The input does not pass through a full FIFO.
//  - out_valid = (count != 0). out_op/result/flags are driven from the head storage entry.
//    They must hold stable while out_valid & !out_ready.
//  - Simultaneous accept+pop, 0<count<DEPTH: count unchanged, both pointers advance.
//  - Accept+pop with count==0 is impossible (out_valid=0): count goes to 1.
//  - Pointers wrap modulo DEPTH. Count is a separate counter of log2(DEPTH)+1 bits.
//  - op_count increments by 1 on each accept and wraps 2^CNT_W-1 -> 0. No saturation.
//  - in_valid with in_ready=0 is ignored. No state changes. Upstream must hold inputs stable.
//  - Reset mid-operation discards all queued entries immediately. No partial output.
//  - out_* when out_valid=0: they show the stale head storage. Consumers ignore them;
//    the bench must not check them.
// TESTING
//  1 Reset: rst_n=0 async mid-cycle -> out_valid=0, op_count=0, in_ready=1 and out_* =0 at once,
//    with no clk edge needed.
//  2 Add path: s=00,y0=4'hF,cout=1, out_ready=1 -> next cycle out_result=F, flags=100, out_op=00.
//    Then s=00,y0=0,cout=1 -> flags=101.
//  3 Sub/cmp/and: s=01,y1=4'h3,sign=1 -> flags=010 (carry masked). s=10,y2=0 -> flags=001.
//    s=11,y3=4'h5,cout=1,sign=1 -> flags=000.
//  4 Backpressure: out_ready=0, push 3 ops (A,B,C) -> in_ready=0 after 2. C is not accepted while
//    held. out_result stays A. Release out_ready -> A,B,C drain in order; op_count=3.
//  5 Full+pop: with 2 queued, in_valid=1 & out_ready=1 -> pop only that cycle.
//    Accept on the next cycle. Order preserved.
//  6 Wrap: 256 accepted ops with CNT_W=8 -> op_count=0. Ptr wrap: 10 ops streamed, out_ready=1,
//    all results match in order.

Source files
------------

// File: rtl/alu_result_capture.sv
// ALU result capture stage: selects the result of the active op, derives flags and
// queues {op, result, flags} in a small FIFO with a valid/ready output and an op counter.
module alu_result_capture #(
    parameter int W     = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       s,
    input  logic [W-1:0]     y0,
    input  logic [W-1:0]     y1,
    input  logic [W-1:0]     y2,
    input  logic [W-1:0]     y3,
    input  logic             cout,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_op,
    output logic [W-1:0]     out_result,
    output logic [2:0]       out_flags,
    output logic [CNT_W-1:0] op_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]    mem_op    [DEPTH];
    logic [W-1:0]  mem_result[DEPTH];
    logic [2:0]    mem_flags [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          accept;
    logic          pop;
    logic [W-1:0]  sel_result;
    logic [2:0]    sel_flags;

    always_comb begin
        sel_result = y0;
        case (s)
            2'b00:   sel_result = y0;
            2'b01:   sel_result = y1;
            2'b10:   sel_result = y2;
            default: sel_result = y3;
        endcase
    end

    // Carry and sign only have meaning for the add and subtract ops respectively.
    assign sel_flags = {(s == 2'b00) & cout, (s == 2'b01) & sign, sel_result == '0};

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_op     = mem_op[rd_ptr];
    assign out_result = mem_result[rd_ptr];
    assign out_flags  = mem_flags[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_op[i]     <= '0;
                mem_result[i] <= '0;
                mem_flags[i]  <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                mem_op[wr_ptr]     <= s;
                mem_result[wr_ptr] <= sel_result;
                mem_flags[wr_ptr]  <= sel_flags;
                wr_ptr             <= wr_ptr + AW'(1);
                op_count           <= op_count + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture: vector table for the result/flag paths plus
// hand-written sequences for reset, backpressure, full+pop and pointer/counter wrap.
module tb_alu_result_capture;

    localparam int W     = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       s;
    logic [W-1:0]     y0, y1, y2, y3;
    logic             cout;
    logic             sign;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_op;
    logic [W-1:0]     out_result;
    logic [2:0]       out_flags;
    logic [CNT_W-1:0] op_count;

    int total;
    int passed;

    typedef struct {
        logic [1:0]   s;
        logic [W-1:0] y0, y1, y2, y3;
        logic         cout;
        logic         sign;
        logic [W-1:0] exp_result;
        logic [2:0]   exp_flags;
    } vec_t;

    vec_t vecs[8];

    alu_result_capture #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .cout(cout), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_result(out_result), .out_flags(out_flags),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] sel,
                                 input logic [W-1:0] a0, input logic [W-1:0] a1,
                                 input logic [W-1:0] a2, input logic [W-1:0] a3,
                                 input logic co, input logic sg);
        in_valid = v;
        s = sel;
        y0 = a0; y1 = a1; y2 = a2; y3 = a3;
        cout = co;
        sign = sg;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);

        // {s, y0, y1, y2, y3, cout, sign, expected result, expected flags}
        vecs[0] = '{2'b00, 4'hF, 4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 4'hF, 3'b100};
        vecs[1] = '{2'b00, 4'h0, 4'h1, 4'h2, 4'h3, 1'b1, 1'b1, 4'h0, 3'b101};
        vecs[2] = '{2'b01, 4'hA, 4'h3, 4'h2, 4'h1, 1'b1, 1'b1, 4'h3, 3'b010};
        vecs[3] = '{2'b10, 4'h7, 4'h6, 4'h0, 4'h5, 1'b1, 1'b1, 4'h0, 3'b001};
        vecs[4] = '{2'b11, 4'h0, 4'h0, 4'h0, 4'h5, 1'b1, 1'b1, 4'h5, 3'b000};
        vecs[5] = '{2'b00, 4'h7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h7, 3'b000};
        vecs[6] = '{2'b01, 4'h5, 4'h0, 4'h5, 4'h5, 1'b1, 1'b0, 4'h0, 3'b001};
        vecs[7] = '{2'b10, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 3'b000};

        #12 rst_n = 1'b1;

        // Asynchronous reset mid-cycle with a non-zero entry at the head
        @(negedge clk);
        applyStimulus(1'b1, 2'b01, '0, 4'h9, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        checkOutput("pre_reset_result", 32'(out_result), 32'h9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_op_count", 32'(op_count), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_op", 32'(out_op), 32'd0);
        checkOutput("reset_out_result", 32'(out_result), 32'd0);
        checkOutput("reset_out_flags", 32'(out_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven result mux and flag checks
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            applyStimulus(1'b1, vecs[i].s, vecs[i].y0, vecs[i].y1, vecs[i].y2, vecs[i].y3,
                          vecs[i].cout, vecs[i].sign);
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("vec%0d_op", i), 32'(out_op), 32'(vecs[i].s));
            checkOutput($sformatf("vec%0d_result", i), 32'(out_result), 32'(vecs[i].exp_result));
            checkOutput($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].exp_flags));
        end
        @(negedge clk);
        checkOutput("table_drained", 32'(out_valid), 32'd0);
        checkOutput("table_op_count", 32'(op_count), 32'd8);

        // Backpressure: A and B fill the FIFO, C is held off until a slot frees
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b00, 4'hA, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 4'hB, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 4'hC, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("bp_full_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_result", k), 32'(out_result), 32'hA);
            checkOutput($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("bp_hold%0d_op_count", k), 32'(op_count), 32'd2);
        end
        // Full + pop: this edge only pops A, C must wait for the next edge
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("fullpop_result_b", 32'(out_result), 32'hB);
        checkOutput("fullpop_op_count", 32'(op_count), 32'd2);
        checkOutput("fullpop_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("drain_result_c", 32'(out_result), 32'hC);
        checkOutput("drain_valid_c", 32'(out_valid), 32'd1);
        checkOutput("bp_op_count", 32'(op_count), 32'd3);
        @(negedge clk);
        checkOutput("bp_empty", 32'(out_valid), 32'd0);

        // Streaming 256 ops: pointer wrap on the first ten, op_count wrap at the end
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i > 0 && i <= 10) begin
                checkOutput($sformatf("stream%0d_result", i - 1), 32'(out_result), 32'((i - 1) % 16));
                checkOutput($sformatf("stream%0d_flags", i - 1), 32'(out_flags),
                            ((i - 1) % 16 == 0) ? 32'd1 : 32'd0);
            end
            if (i == 255) checkOutput("stream_op_count_255", 32'(op_count), 32'd255);
            applyStimulus(1'b1, 2'b00, W'(i % 16), '0, '0, '0, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("stream_last_result", 32'(out_result), 32'hF);
        checkOutput("op_count_wrap", 32'(op_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
